// File: rtl/vfu_mask_router.sv
// Tagged mask distributor: looks up each mask word's owning functional unit and queues it in that unit's FIFO.
// Optional zero-latency bypass into an empty, ready FIFO when VFU_MASK_ROUTER_BYPASS_EN is defined.
module vfu_mask_router #(
   parameter int NrFUs     = 2,
   parameter int NrVInsn   = 8,
   parameter int Depth     = 4,
   parameter int StrbWidth = 8,
   localparam int FuIdxW   = (NrFUs > 1) ? $clog2(NrFUs) : 1,
   localparam int VidW     = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       issue_valid_i,
   input  logic [VidW-1:0]            issue_vid_i,
   input  logic [FuIdxW-1:0]          issue_fu_i,
   input  logic                       release_valid_i,
   input  logic [VidW-1:0]            release_vid_i,
   input  logic [StrbWidth-1:0]       mask_i,
   input  logic [VidW-1:0]            mask_vid_i,
   input  logic                       mask_valid_i,
   output logic                       mask_ready_o,
   output logic [NrFUs*StrbWidth-1:0] fu_mask_o,
   output logic [NrFUs*VidW-1:0]      fu_mask_vid_o,
   output logic [NrFUs-1:0]           fu_mask_valid_o,
   input  logic [NrFUs-1:0]           fu_mask_ready_i,
   output logic                       busy_o,
   output logic                       err_unmapped_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = $clog2(Depth + 1);

   logic [NrVInsn-1:0] own_valid;
   logic [FuIdxW-1:0]  own_fu [NrVInsn];
   logic               hit_valid;
   logic [FuIdxW-1:0]  hit_fu;
   logic [NrFUs-1:0]   sel, full, empty, acc, byp, wr, rd;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   // Release is applied first so a same-cycle issue of the same ID wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         own_valid <= '0;
      end else begin
         if (release_valid_i)
            own_valid[release_vid_i] <= 1'b0;
         if (issue_valid_i) begin
            own_valid[issue_vid_i] <= 1'b1;
            own_fu[issue_vid_i]    <= issue_fu_i;
         end
      end
   end

   assign hit_valid = own_valid[mask_vid_i];
   assign hit_fu    = own_fu[mask_vid_i];

   always_comb begin
      sel = '0;
      for (int k = 0; k < NrFUs; k++)
         sel[k] = hit_valid && (hit_fu == FuIdxW'(k));
   end

   // Unowned words are consumed (ready high) and dropped; only a full target FIFO stalls.
   assign mask_ready_o = ~|(sel & full);
   assign acc          = {NrFUs{mask_valid_i}} & sel & ~full;
   assign busy_o       = |(~empty);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         err_unmapped_o <= 1'b0;
      else if (mask_valid_i && !hit_valid)
         err_unmapped_o <= 1'b1;
   end

   for (genvar k = 0; k < NrFUs; k++) begin : g_fu
      logic [StrbWidth-1:0] mem_mask [Depth];
      logic [VidW-1:0]      mem_vid  [Depth];
      logic [PtrW-1:0]      rptr, wptr;
      logic [CntW-1:0]      cnt;

      assign full[k]  = (cnt == CntW'(Depth));
      assign empty[k] = (cnt == '0);
`ifdef VFU_MASK_ROUTER_BYPASS_EN
      assign byp[k] = acc[k] & empty[k] & fu_mask_ready_i[k];
`else
      assign byp[k] = 1'b0;
`endif
      assign wr[k] = acc[k] & ~byp[k];
      assign rd[k] = ~empty[k] & fu_mask_ready_i[k];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
         end else begin
            if (wr[k]) begin
               mem_mask[wptr] <= mask_i;
               mem_vid[wptr]  <= mask_vid_i;
               wptr           <= ptr_inc(wptr);
            end
            if (rd[k])
               rptr <= ptr_inc(rptr);
            case ({wr[k], rd[k]})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end

`ifdef VFU_MASK_ROUTER_BYPASS_EN
      assign fu_mask_o[k*StrbWidth +: StrbWidth] = empty[k] ? mask_i : mem_mask[rptr];
      assign fu_mask_vid_o[k*VidW +: VidW]       = empty[k] ? mask_vid_i : mem_vid[rptr];
      assign fu_mask_valid_o[k]                  = ~empty[k] | byp[k];
`else
      assign fu_mask_o[k*StrbWidth +: StrbWidth] = mem_mask[rptr];
      assign fu_mask_vid_o[k*VidW +: VidW]       = mem_vid[rptr];
      assign fu_mask_valid_o[k]                  = ~empty[k];
`endif
   end

endmodule

// File: tb/tb_vfu_mask_router.sv
// Directed self-checking bench for vfu_mask_router (NrFUs=2, NrVInsn=8, Depth=4, StrbWidth=8).
module tb_vfu_mask_router;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        issue_valid_i;
   logic [2:0]  issue_vid_i;
   logic        issue_fu_i;
   logic        release_valid_i;
   logic [2:0]  release_vid_i;
   logic [7:0]  mask_i;
   logic [2:0]  mask_vid_i;
   logic        mask_valid_i;
   logic        mask_ready_o;
   logic [15:0] fu_mask_o;
   logic [5:0]  fu_mask_vid_o;
   logic [1:0]  fu_mask_valid_o;
   logic [1:0]  fu_mask_ready_i;
   logic        busy_o;
   logic        err_unmapped_o;

   int vecCount = 0;
   int errCount = 0;

   vfu_mask_router dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_vid_i(issue_vid_i), .issue_fu_i(issue_fu_i),
      .release_valid_i(release_valid_i), .release_vid_i(release_vid_i),
      .mask_i(mask_i), .mask_vid_i(mask_vid_i), .mask_valid_i(mask_valid_i),
      .mask_ready_o(mask_ready_o),
      .fu_mask_o(fu_mask_o), .fu_mask_vid_o(fu_mask_vid_o),
      .fu_mask_valid_o(fu_mask_valid_o), .fu_mask_ready_i(fu_mask_ready_i),
      .busy_o(busy_o), .err_unmapped_o(err_unmapped_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle's inputs just after a rising edge and lets combinational outputs settle.
   task automatic applyStimulus(input logic iv, input logic [2:0] ivid, input logic ifu,
                                input logic rv, input logic [2:0] rvid,
                                input logic mv, input logic [2:0] mvid, input logic [7:0] m,
                                input logic [1:0] rdy);
      issue_valid_i   = iv;
      issue_vid_i     = ivid;
      issue_fu_i      = ifu;
      release_valid_i = rv;
      release_vid_i   = rvid;
      mask_valid_i    = mv;
      mask_vid_i      = mvid;
      mask_i          = m;
      fu_mask_ready_i = rdy;
      #1;
   endtask

   task automatic idle(input logic [1:0] rdy);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, rdy);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulseReset();
      idle(2'b00);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      idle(2'b00);
      step();
      step();
      rst_i = 1'b0;

      $display("[TB] reset and idle");
      idle(2'b11);
      checkOutput("rst_valid", fu_mask_valid_o, 2'b00);
      checkOutput("rst_busy", busy_o, 1'b0);
      checkOutput("rst_err", err_unmapped_o, 1'b0);
      checkOutput("rst_ready", mask_ready_o, 1'b1);

      $display("[TB] single word to FU1");
      applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b11);
      step();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 8'hA5, 2'b11);
      checkOutput("fu1_ready", mask_ready_o, 1'b1);
`ifdef VFU_MASK_ROUTER_BYPASS_EN
      checkOutput("fu1_byp_valid", fu_mask_valid_o, 2'b10);
      checkOutput("fu1_byp_mask", fu_mask_o[15:8], 8'hA5);
      checkOutput("fu1_byp_vid", fu_mask_vid_o[5:3], 3'd3);
      step();
      idle(2'b11);
      checkOutput("fu1_byp_after", fu_mask_valid_o, 2'b00);
      checkOutput("fu1_byp_busy", busy_o, 1'b0);
`else
      checkOutput("fu1_same_cycle", fu_mask_valid_o, 2'b00);
      step();
      idle(2'b11);
      checkOutput("fu1_valid", fu_mask_valid_o, 2'b10);
      checkOutput("fu1_mask", fu_mask_o[15:8], 8'hA5);
      checkOutput("fu1_vid", fu_mask_vid_o[5:3], 3'd3);
      checkOutput("fu1_busy", busy_o, 1'b1);
      step();
      idle(2'b11);
      checkOutput("fu1_popped", fu_mask_valid_o, 2'b00);
`endif

      $display("[TB] fill FU0 FIFO past depth");
      applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00);
      step();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 8'h10 + 8'(i), 2'b00);
         checkOutput($sformatf("fill_ready%0d", i), mask_ready_o, 1'b1);
         step();
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 8'h14, 2'b00);
      checkOutput("full_stall", mask_ready_o, 1'b0);
      checkOutput("full_valid", fu_mask_valid_o, 2'b01);
      step();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 8'h14, 2'b01);
      checkOutput("full_pop_stall", mask_ready_o, 1'b0);
      checkOutput("drain_head0", fu_mask_o[7:0], 8'h10);
      step();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 8'h14, 2'b01);
      checkOutput("fifth_ready", mask_ready_o, 1'b1);
      checkOutput("drain_head1", fu_mask_o[7:0], 8'h11);
      step();
      for (int j = 0; j < 3; j++) begin
         idle(2'b01);
         checkOutput($sformatf("drain_valid%0d", j + 2), fu_mask_valid_o, 2'b01);
         checkOutput($sformatf("drain_head%0d", j + 2), fu_mask_o[7:0], 8'h12 + 8'(j));
         checkOutput($sformatf("drain_vid%0d", j + 2), fu_mask_vid_o[2:0], 3'd1);
         step();
      end
      idle(2'b01);
      checkOutput("drain_empty", fu_mask_valid_o, 2'b00);
      checkOutput("drain_busy", busy_o, 1'b0);

      $display("[TB] unmapped tag");
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 8'h3C, 2'b11);
      checkOutput("unmap_ready", mask_ready_o, 1'b1);
      step();
      idle(2'b11);
      checkOutput("unmap_err", err_unmapped_o, 1'b1);
      checkOutput("unmap_valid", fu_mask_valid_o, 2'b00);
      checkOutput("unmap_busy", busy_o, 1'b0);
      step();
      checkOutput("unmap_sticky", err_unmapped_o, 1'b1);
      pulseReset();
      checkOutput("unmap_cleared", err_unmapped_o, 1'b0);

      $display("[TB] issue and mask in the same cycle");
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h77, 2'b00);
      step();
      idle(2'b00);
      checkOutput("sameclk_err", err_unmapped_o, 1'b1);
      checkOutput("sameclk_drop", fu_mask_valid_o, 2'b00);
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h21, 2'b00);
      checkOutput("nextclk_ready", mask_ready_o, 1'b1);
      step();
      idle(2'b00);
      checkOutput("nextclk_valid", fu_mask_valid_o, 2'b01);
      checkOutput("nextclk_mask", fu_mask_o[7:0], 8'h21);
      checkOutput("nextclk_vid", fu_mask_vid_o[2:0], 3'd2);

      $display("[TB] release with queued words");
      pulseReset();
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 2'b00);
      step();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h31 + 8'(i), 2'b00);
         step();
      end
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 2'b00);
      step();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h44, 2'b00);
      checkOutput("rel_drop_ready", mask_ready_o, 1'b1);
      step();
      idle(2'b00);
      checkOutput("rel_err", err_unmapped_o, 1'b1);
      checkOutput("rel_busy", busy_o, 1'b1);
      for (int j = 0; j < 3; j++) begin
         idle(2'b01);
         checkOutput($sformatf("rel_valid%0d", j), fu_mask_valid_o, 2'b01);
         checkOutput($sformatf("rel_head%0d", j), fu_mask_o[7:0], 8'h31 + 8'(j));
         step();
      end
      idle(2'b00);
      checkOutput("rel_no_extra", fu_mask_valid_o, 2'b00);
      applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 8'h00, 2'b00);
      step();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h55, 2'b00);
      checkOutput("issrel_ready", mask_ready_o, 1'b1);
      step();
      idle(2'b00);
      checkOutput("issrel_valid", fu_mask_valid_o, 2'b10);
      checkOutput("issrel_mask", fu_mask_o[15:8], 8'h55);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
